// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared state encoding and sizing helper for the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam logic [2:0] lp_ST_IDLE       = 3'd0;
    localparam logic [2:0] lp_ST_LOAD       = 3'd1;
    localparam logic [2:0] lp_ST_WAIT_START = 3'd2;
    localparam logic [2:0] lp_ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] lp_ST_GAP        = 3'd4;
    localparam logic [2:0] lp_ST_HOLD       = 3'd5;
    localparam logic [2:0] lp_ST_RELEASE    = 3'd6;

    function automatic int grant_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin picker: first valid index at or after
//            the pointer, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int p_NUM_REQ  = 4,
    parameter int p_ID_WIDTH = 2
) (
    input  logic [p_NUM_REQ-1:0]  iv_valid,
    input  logic [p_ID_WIDTH-1:0] iv_pointer,
    output logic [p_ID_WIDTH-1:0] ov_winner,
    output logic                  o_any_valid
);

    localparam logic [p_ID_WIDTH:0] c_NUM = (p_ID_WIDTH+1)'(p_NUM_REQ);

    logic [p_ID_WIDTH:0]   w_sum;
    logic [p_ID_WIDTH-1:0] w_idx;

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        ov_winner   = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = p_NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, iv_pointer} + (p_ID_WIDTH+1)'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_idx = w_sum[p_ID_WIDTH-1:0];
            if (iv_valid[w_idx]) begin
                ov_winner   = w_idx;
                o_any_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART transmitter between byte
//            requesters, with optional inter-frame gap and packet hold.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int p_NUM_REQ       = 4,
    parameter int p_DATA_WIDTH    = 8,
    parameter int p_PACKET_MODE   = 1,
    parameter int p_GAP_CYCLES    = 0,
    parameter int p_START_TIMEOUT = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [p_NUM_REQ-1:0]              iv_req_valid,
    input  logic [p_NUM_REQ-1:0]              iv_req_last,
    input  logic [p_NUM_REQ*p_DATA_WIDTH-1:0] iv_req_data,
    output logic [p_NUM_REQ-1:0]              ov_req_ack,
    output logic [p_DATA_WIDTH-1:0]           ov_tx_data,
    output logic                              o_tx_data_ready,
    input  logic                              i_tx_busy,
    output logic [$clog2(p_NUM_REQ)-1:0]      ov_grant_id,
    output logic                              o_grant_valid,
    output logic                              o_error
);

    localparam int c_ID_W  = grant_id_width(p_NUM_REQ);
    localparam int c_GAP_W = (p_GAP_CYCLES > 1) ? $clog2(p_GAP_CYCLES) : 1;
    localparam int c_TO_W  = $clog2(p_START_TIMEOUT);

    localparam logic [c_ID_W-1:0]    c_LAST_ID  = c_ID_W'(p_NUM_REQ - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST = (p_GAP_CYCLES > 1) ? c_GAP_W'(p_GAP_CYCLES - 1) : '0;
    localparam logic [c_TO_W-1:0]    c_TO_LAST  = c_TO_W'(p_START_TIMEOUT - 1);
    localparam logic [p_NUM_REQ-1:0] c_ONE_HOT0 = p_NUM_REQ'(1);

    logic [2:0]              r_state;
    logic [c_ID_W-1:0]       r_rr_ptr;
    logic [c_ID_W-1:0]       r_grant_id;
    logic [p_DATA_WIDTH-1:0] r_tx_data;
    logic                    r_last;
    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic [c_TO_W-1:0]       r_timeout_cnt;
    logic [p_NUM_REQ-1:0]    r_req_ack;
    logic                    r_tx_data_ready;
    logic                    r_grant_valid;
    logic                    r_error;

    logic [c_ID_W-1:0]       w_winner;
    logic                    w_any_valid;

    rr_priority_picker #(
        .p_NUM_REQ  (p_NUM_REQ),
        .p_ID_WIDTH (c_ID_W)
    ) u_picker (
        .iv_valid    (iv_req_valid),
        .iv_pointer  (r_rr_ptr),
        .ov_winner   (w_winner),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= lp_ST_IDLE;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_tx_data       <= '0;
            r_last          <= 1'b0;
            r_gap_cnt       <= '0;
            r_timeout_cnt   <= '0;
            r_req_ack       <= '0;
            r_tx_data_ready <= 1'b0;
            r_grant_valid   <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_req_ack       <= '0;
            r_tx_data_ready <= 1'b0;
            r_error         <= 1'b0;
            case (r_state)
                lp_ST_IDLE: begin
                    if (w_any_valid && !i_tx_busy) begin
                        r_grant_id    <= w_winner;
                        r_tx_data     <= iv_req_data[int'(w_winner)*p_DATA_WIDTH +: p_DATA_WIDTH];
                        r_last        <= iv_req_last[w_winner];
                        r_grant_valid <= 1'b1;
                        r_state       <= lp_ST_LOAD;
                    end
                end
                lp_ST_LOAD: begin
                    r_tx_data_ready <= 1'b1;
                    r_req_ack       <= c_ONE_HOT0 << r_grant_id;
                    r_timeout_cnt   <= '0;
                    r_state         <= lp_ST_WAIT_START;
                end
                lp_ST_WAIT_START: begin
                    if (i_tx_busy) begin
                        r_state <= lp_ST_WAIT_DONE;
                    end else if (r_timeout_cnt == c_TO_LAST) begin
                        // Byte is lost; the ack already given is not revoked.
                        r_error <= 1'b1;
                        r_state <= lp_ST_RELEASE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end
                lp_ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_gap_cnt <= '0;
                        r_state   <= lp_ST_GAP;
                    end
                end
                lp_ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        if ((p_PACKET_MODE != 0) && !r_last) begin
                            r_state <= lp_ST_HOLD;
                        end else begin
                            r_state <= lp_ST_RELEASE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                lp_ST_HOLD: begin
                    if (iv_req_valid[r_grant_id]) begin
                        r_tx_data <= iv_req_data[int'(r_grant_id)*p_DATA_WIDTH +: p_DATA_WIDTH];
                        r_last    <= iv_req_last[r_grant_id];
                        r_state   <= lp_ST_LOAD;
                    end
                end
                lp_ST_RELEASE: begin
                    r_rr_ptr      <= (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
                    r_grant_valid <= 1'b0;
                    r_state       <= lp_ST_IDLE;
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= lp_ST_IDLE;
                end
            endcase
        end
    end

    assign ov_req_ack      = r_req_ack;
    assign ov_tx_data      = r_tx_data;
    assign o_tx_data_ready = r_tx_data_ready;
    assign ov_grant_id     = r_grant_id;
    assign o_grant_valid   = r_grant_valid;
    assign o_error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter with a simple
//            transmitter model; instance 0 packet mode/no gap, instance 1 gap 5.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int c_N     = 4;
    localparam int c_W     = 8;
    localparam int c_FRAME = 20;
    localparam int c_TO    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [c_N-1:0]     req_valid   [2];
    logic [c_N-1:0]     req_last    [2];
    logic [c_N*c_W-1:0] req_data    [2];
    logic [c_N-1:0]     req_ack     [2];
    logic [c_W-1:0]     tx_data     [2];
    logic               tx_ready    [2];
    logic [1:0]         grant_id    [2];
    logic               grant_valid [2];
    logic               error_o     [2];

    logic [7:0] q_data [2][4][16];
    logic       q_last [2][4][16];
    logic [3:0] q_wr   [2][4] = '{default: '0};
    logic [3:0] q_rd   [2][4] = '{default: '0};
    int         ack_cnt   [2] = '{0, 0};
    int         multi_hot     = 0;

    logic       m_busy [2] = '{1'b0, 1'b0};
    int         m_cnt  [2] = '{0, 0};
    logic [7:0] log_d  [2][64];
    int         log_n  [2] = '{0, 0};
    logic       kill = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.p_NUM_REQ(4), .p_DATA_WIDTH(8), .p_PACKET_MODE(1),
                      .p_GAP_CYCLES(0), .p_START_TIMEOUT(c_TO)) u_dut0 (
        .i_clk(clk), .i_reset(rst),
        .iv_req_valid(req_valid[0]), .iv_req_last(req_last[0]), .iv_req_data(req_data[0]),
        .ov_req_ack(req_ack[0]), .ov_tx_data(tx_data[0]), .o_tx_data_ready(tx_ready[0]),
        .i_tx_busy(m_busy[0]), .ov_grant_id(grant_id[0]), .o_grant_valid(grant_valid[0]),
        .o_error(error_o[0])
    );

    uart_tx_arbiter #(.p_NUM_REQ(4), .p_DATA_WIDTH(8), .p_PACKET_MODE(0),
                      .p_GAP_CYCLES(5), .p_START_TIMEOUT(c_TO)) u_dut1 (
        .i_clk(clk), .i_reset(rst),
        .iv_req_valid(req_valid[1]), .iv_req_last(req_last[1]), .iv_req_data(req_data[1]),
        .ov_req_ack(req_ack[1]), .ov_tx_data(tx_data[1]), .o_tx_data_ready(tx_ready[1]),
        .i_tx_busy(m_busy[1]), .ov_grant_id(grant_id[1]), .o_grant_valid(grant_valid[1]),
        .o_error(error_o[1])
    );

    // Requester FIFOs present their head entry until acked.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = '0;
            req_last[g]  = '0;
            req_data[g]  = '0;
            for (int k = 0; k < c_N; k++) begin
                req_valid[g][k]       = (q_wr[g][k] != q_rd[g][k]);
                req_last[g][k]        = q_last[g][k][q_rd[g][k]];
                req_data[g][k*8 +: 8] = q_data[g][k][q_rd[g][k]];
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < c_N; k++) begin
                if (req_ack[g][k]) q_rd[g][k] = q_rd[g][k] + 4'd1;
            end
            ack_cnt[g] = ack_cnt[g] + $countones(req_ack[g]);
            if ($countones(req_ack[g]) > 1) multi_hot = multi_hot + 1;
        end
    end

    // Transmitter model: frame of c_FRAME clocks, logs each accepted byte.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_busy[g] <= 1'b0;
                m_cnt[g]  <= 0;
            end else if (m_busy[g]) begin
                if (m_cnt[g] == c_FRAME - 1) m_busy[g] <= 1'b0;
                else                         m_cnt[g]  <= m_cnt[g] + 1;
            end else if (tx_ready[g] && !(g == 0 && kill)) begin
                m_busy[g]            <= 1'b1;
                m_cnt[g]             <= 0;
                log_d[g][log_n[g]]   <= tx_data[g];
                log_n[g]             <= log_n[g] + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input int k, input logic [7:0] d, input logic l);
        q_data[g][k][q_wr[g][k]] = d;
        q_last[g][k][q_wr[g][k]] = l;
        q_wr[g][k] = q_wr[g][k] + 4'd1;
    endtask

    task automatic wait_busy(input int g, input logic level, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (m_busy[g] == level) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_log(input int g, input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (log_n[g] >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic ticks_until_ready(input int g, output int lat);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (tx_ready[g]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (req_ack[0] !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", req_ack[0]); end
        checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", tx_ready[0]); end
        checks++; if (tx_data[0] !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", tx_data[0]); end
        checks++; if (grant_id[0] !== 2'd0) begin errors++; $display("FAIL reset_gid got=%0d exp=0", grant_id[0]); end
        checks++; if (grant_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_gvalid got=%b exp=0", grant_valid[0]); end
        checks++; if (error_o[0] !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error_o[0]); end
        checks++; if (grant_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_gvalid1 got=%b exp=0", grant_valid[1]); end
    endtask

    task automatic test_single();
        int lat;
        bit ok;
        push(0, 2, 8'h5A, 1'b1);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (req_ack[0] != 4'b0) begin
                lat = c;
                break;
            end
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_ack_latency got=%0d exp=2", lat); end
        checks++; if (req_ack[0] !== 4'b0100) begin errors++; $display("FAIL single_ack_vec got=%b exp=0100", req_ack[0]); end
        checks++; if (tx_ready[0] !== 1'b1 || tx_data[0] !== 8'h5A) begin
            errors++; $display("FAIL single_load got=%b/%h exp=1/5a", tx_ready[0], tx_data[0]);
        end
        wait_busy(0, 1'b1, ok);
        wait_busy(0, 1'b0, ok);
        checks++; if (!ok || grant_valid[0] !== 1'b1) begin
            errors++; $display("FAIL single_busy_fall ok=%b gvalid=%b exp=1/1", ok, grant_valid[0]);
        end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!grant_valid[0]) begin
                lat = c;
                break;
            end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL single_grant_drop got=%0d exp=3", lat); end
        checks++; if (log_n[0] !== 1 || log_d[0][0] !== 8'h5A) begin
            errors++; $display("FAIL single_line got=%0d/%h exp=1/5a", log_n[0], log_d[0][0]);
        end
        // Pointer should now be 3: req3 beats req2.
        push(0, 2, 8'hC2, 1'b1);
        push(0, 3, 8'hC3, 1'b1);
        wait_log(0, 3, ok);
        checks++; if (!ok || log_d[0][1] !== 8'hC3 || log_d[0][2] !== 8'hC2) begin
            errors++; $display("FAIL single_pointer ok=%b got=%h,%h exp=c3,c2", ok, log_d[0][1], log_d[0][2]);
        end
        push(0, 3, 8'hD3, 1'b1);
        wait_log(0, 4, ok);
        checks++; if (!ok || log_d[0][3] !== 8'hD3) begin
            errors++; $display("FAIL single_req3 ok=%b got=%h exp=d3", ok, log_d[0][3]);
        end
        repeat (10) tick();
    endtask

    task automatic test_round_robin();
        int base, acks0, lat;
        bit ok;
        logic [7:0] exp_b;
        for (int r = 0; r < 2; r++) begin
            base  = log_n[0];
            acks0 = ack_cnt[0];
            for (int k = 0; k < 4; k++) begin
                exp_b = 8'h10 + 8'(k) + (r == 1 ? 8'h10 : 8'h00);
                push(0, k, exp_b, 1'b1);
            end
            if (r == 0) begin
                wait_busy(0, 1'b1, ok);
                wait_busy(0, 1'b0, ok);
                ticks_until_ready(0, lat);
                checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL rr_busy_to_ready ok=%b got=%0d exp=5", ok, lat); end
            end
            wait_log(0, base + 4, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_timeout round=%0d got=%0d bytes exp=4", r, log_n[0] - base); end
            for (int k = 0; k < 4; k++) begin
                exp_b = 8'h10 + 8'(k) + (r == 1 ? 8'h10 : 8'h00);
                checks++; if (log_d[0][base + k] !== exp_b) begin
                    errors++; $display("FAIL rr_order round=%0d slot=%0d got=%h exp=%h", r, k, log_d[0][base + k], exp_b);
                end
            end
            repeat (30) tick();
            checks++; if (ack_cnt[0] - acks0 !== 4) begin
                errors++; $display("FAIL rr_ack_count round=%0d got=%0d exp=4", r, ack_cnt[0] - acks0);
            end
        end
    endtask

    task automatic test_packet();
        int base;
        bit ok;
        bit seen;
        base = log_n[0];
        push(0, 1, 8'hA0, 1'b0);
        push(0, 1, 8'hA1, 1'b0);
        push(0, 1, 8'hA2, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (req_ack[0][1]) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL packet_first_ack got=0 exp=1"); end
        push(0, 0, 8'hB0, 1'b1);
        wait_log(0, base + 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL packet_timeout got=%0d bytes exp=4", log_n[0] - base); end
        checks++; if (log_d[0][base] !== 8'hA0 || log_d[0][base + 1] !== 8'hA1) begin
            errors++; $display("FAIL packet_head got=%h,%h exp=a0,a1", log_d[0][base], log_d[0][base + 1]);
        end
        checks++; if (log_d[0][base + 2] !== 8'hA2 || log_d[0][base + 3] !== 8'hB0) begin
            errors++; $display("FAIL packet_tail got=%h,%h exp=a2,b0", log_d[0][base + 2], log_d[0][base + 3]);
        end
        repeat (30) tick();
    endtask

    task automatic test_gap();
        int lat;
        bit ok;
        push(1, 0, 8'h61, 1'b1);
        push(1, 1, 8'h62, 1'b1);
        wait_busy(1, 1'b1, ok);
        wait_busy(1, 1'b0, ok);
        ticks_until_ready(1, lat);
        checks++; if (!ok || lat !== 9) begin errors++; $display("FAIL gap_busy_to_ready ok=%b got=%0d exp=9", ok, lat); end
        wait_log(1, 2, ok);
        checks++; if (!ok || log_d[1][0] !== 8'h61 || log_d[1][1] !== 8'h62) begin
            errors++; $display("FAIL gap_order ok=%b got=%h,%h exp=61,62", ok, log_d[1][0], log_d[1][1]);
        end
        repeat (30) tick();
    endtask

    task automatic test_timeout();
        int base, lat;
        bit ok;
        base = log_n[0];
        kill = 1'b1;
        push(0, 1, 8'hE1, 1'b1);
        push(0, 2, 8'hE2, 1'b1);
        ticks_until_ready(0, lat);
        checks++; if (lat < 0 || grant_id[0] !== 2'd1) begin
            errors++; $display("FAIL timeout_grant lat=%0d got=%0d exp=1", lat, grant_id[0]);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (error_o[0]) begin
                lat = c;
                break;
            end
        end
        checks++; if (lat !== c_TO) begin errors++; $display("FAIL timeout_error_delay got=%0d exp=%0d", lat, c_TO); end
        kill = 1'b0;
        tick();
        checks++; if (error_o[0] !== 1'b0) begin errors++; $display("FAIL timeout_error_pulse got=%b exp=0", error_o[0]); end
        wait_log(0, base + 1, ok);
        checks++; if (!ok || log_d[0][base] !== 8'hE2) begin
            errors++; $display("FAIL timeout_next ok=%b got=%h exp=e2", ok, log_d[0][base]);
        end
        repeat (30) tick();
    endtask

    task automatic test_reset_midop();
        int base;
        bit ok;
        push(0, 2, 8'h77, 1'b1);
        wait_busy(0, 1'b1, ok);
        repeat (2) tick();
        checks++; if (!ok || grant_valid[0] !== 1'b1) begin
            errors++; $display("FAIL midop_busy ok=%b gvalid=%b exp=1/1", ok, grant_valid[0]);
        end
        push(0, 3, 8'h33, 1'b1);
        push(0, 1, 8'h11, 1'b1);
        base = log_n[0];
        rst = 1'b1;
        tick();
        checks++; if (req_ack[0] !== 4'b0 || tx_ready[0] !== 1'b0 || error_o[0] !== 1'b0) begin
            errors++; $display("FAIL midop_reset_pulses got=%b/%b/%b exp=0/0/0", req_ack[0], tx_ready[0], error_o[0]);
        end
        checks++; if (tx_data[0] !== 8'h00 || grant_id[0] !== 2'd0 || grant_valid[0] !== 1'b0) begin
            errors++; $display("FAIL midop_reset_regs got=%h/%0d/%b exp=00/0/0", tx_data[0], grant_id[0], grant_valid[0]);
        end
        rst = 1'b0;
        wait_log(0, base + 2, ok);
        checks++; if (!ok || log_d[0][base] !== 8'h11 || log_d[0][base + 1] !== 8'h33) begin
            errors++; $display("FAIL midop_resume ok=%b got=%h,%h exp=11,33", ok, log_d[0][base], log_d[0][base + 1]);
        end
        repeat (30) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet();
        test_gap();
        test_timeout();
        test_reset_midop();
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL ack_onehot got=%0d multi-bit acks exp=0", multi_hot); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
